mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of multiply-class ops.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of divide-class ops.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  issue strobe; op, A and B are sampled on the posedge where start=1.
REQ-006 op  input  4  operation code (package encoding).
REQ-007 A  input  32  operand rs, from register-file read port 1.
REQ-008 B  input  32  operand rt, from register-file read port 2.
REQ-009 req  input  1  exception/interrupt pending; blocks issue.
REQ-010 busy  output  1  long operation in progress.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.

Function
REQ-013 Issue SHALL occur only when start=1, req=0, busy=0 and op is not NONE; otherwise the sample SHALL be ignored with no state change.
REQ-014 MTHI/MTLO SHALL write A into HI or LO at the issue edge, with no busy cycles.
REQ-015 MULT/MULTU SHALL compute the signed/unsigned 64-bit product A*B, with HI = bits[63:32] and LO = bits[31:0].
REQ-016 DIV/DIVU SHALL compute the signed/unsigned quotient into LO and the remainder into HI; the remainder takes the dividend's sign.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-018 B=0 on DIV/DIVU SHALL still assert busy for DIV_CYCLES and leave HI/LO unchanged.
REQ-019 State machine IDLE -> RUN -> IDLE; a valid long-op issue loads the counter with MULT_CYCLES or DIV_CYCLES.
REQ-020 busy SHALL be 1 from the cycle after issue for exactly N cycles (N = the loaded count); the counter decrements each cycle.
REQ-021 HI/LO SHALL update on the edge where the counter reaches 0, and busy SHALL be 0 in that cycle.
REQ-022 HI/LO SHALL keep their old values throughout RUN; results are held in pending registers, not exposed early.
REQ-023 A start during RUN SHALL be ignored; the pipeline stalls the instruction using busy|start.
REQ-024 req=1 SHALL NOT cancel an operation already in RUN; it blocks new issue only.
REQ-025 A back-to-back issue on the same edge the counter expires SHALL be ignored, because busy is still 1 on that edge.

Reset
REQ-026 reset SHALL asynchronously force HI=0, LO=0, busy=0, counter=0, state IDLE and pending registers to 0.
REQ-027 reset during RUN SHALL discard the pending result; after release, HI/LO SHALL stay 0 until the next write.

Configuration
REQ-028 Macro MDU_MADD_EN, when defined, SHALL enable MADD/MADDU/MSUB/MSUBU: {HI,LO} plus or minus the signed/unsigned 64-bit product, with MULT_CYCLES latency.
REQ-029 The 64-bit accumulate SHALL use the {HI,LO} value at issue time and wrap modulo 2^64.
REQ-030 Without MDU_MADD_EN, those opcodes SHALL be treated as NONE: ignored, no busy, HI/LO unchanged.

Structure
REQ-031 The shared package SHALL hold the op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
REQ-032 The shared package SHALL also hold the MULT_CYCLES/DIV_CYCLES defaults.
REQ-033 One sub-module, mdu_ctrl, SHALL be used: state machine plus counter, outputting busy and a commit pulse; the datapath stays in mdu.

Verification
REQ-034 MULT A=0xFFFFFFFF, B=2 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU with the same operands -> HI=1, LO=0xFFFFFFFE.
REQ-035 DIV A=-7, B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> busy for 10 cycles, HI/LO unchanged.
REQ-036 MTHI A=0x12345678 -> HI=0x12345678 on the next cycle with busy=0; start with req=1 -> no change.
REQ-037 MULT issued, then start pulsed on cycles 2-5 -> ignored; exactly one commit.
REQ-038 reset asserted at cycle 3 of a DIV -> busy=0 and HI=LO=0 immediately; no commit after release.
REQ-039 With MDU_MADD_EN defined, HI:LO=0:0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles; without the macro, the same stimulus -> no busy and no change.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// controller states and default latencies.
package mdu_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8,
        MSUB  = 4'd9,
        MSUBU = 4'd10
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the pipeline and the MDU; the pipeline side
// is the master, the MDU is the slave.
interface mdu_if;
    import mdu_pkg::*;

    logic        start;
    op_t         op;
    logic [31:0] A;
    logic [31:0] B;
    logic        req;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, A, B, req,
        input  busy, HI, LO
    );

    modport slave (
        input  start, op, A, B, req,
        output busy, HI, LO
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Long-operation sequencer: holds busy for the loaded number of cycles and
// pulses commit on the edge where the countdown reaches zero.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue,
    input  logic [CW-1:0] loadCount,
    output logic          busy,
    output logic          commit
);

    state_t        state, stateNext;
    logic [CW-1:0] count, countNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // busy stays high on the expiring edge, so a same-edge reissue is refused
    always_comb begin
        stateNext = state;
        countNext = count;
        busy      = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    stateNext = RUN;
                    countNext = loadCount;
                end
            end
            RUN: begin
                busy      = 1'b1;
                countNext = count - 1'b1;
                if (count == CW'(1)) begin
                    stateNext = IDLE;
                    commit    = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// HI/LO multiply-divide unit. Define MDU_MADD_EN to enable the
// MADD/MADDU/MSUB/MSUBU accumulate operations; otherwise they are ignored.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);

    localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW        = $clog2(MaxCycles + 1);

    logic [31:0]   hiReg, loReg, pendHi, pendLo;
    logic          pendWrite;
    logic          busy, commit, issue, isLong, opValid, resWrite;
    logic [31:0]   resHi, resLo;
    logic [CW-1:0] loadCount;

    logic [63:0] extA, extB, prodS, prodU;
    logic [31:0] divB, magA, magB, qU, rU, qMag, rMag, qS, rS;

    assign extA  = {{32{bus.A[31]}}, bus.A};
    assign extB  = {{32{bus.B[31]}}, bus.B};
    assign prodS = extA * extB;
    assign prodU = {32'd0, bus.A} * {32'd0, bus.B};

    // Signed divide works on magnitudes; the zero-divisor guard only keeps the
    // arithmetic defined, since a zero divide never writes back.
    assign divB = (bus.B == 32'd0) ? 32'd1 : bus.B;
    assign magA = bus.A[31] ? (32'd0 - bus.A) : bus.A;
    assign magB = (bus.B == 32'd0) ? 32'd1 : (bus.B[31] ? (32'd0 - bus.B) : bus.B);
    assign qU   = bus.A / divB;
    assign rU   = bus.A % divB;
    assign qMag = magA / magB;
    assign rMag = magA % magB;
    assign qS   = (bus.A[31] ^ bus.B[31]) ? (32'd0 - qMag) : qMag;
    assign rS   = bus.A[31] ? (32'd0 - rMag) : rMag;

    // Decode: result staged for commit, plus which ops occupy the controller
    always_comb begin
        resHi     = hiReg;
        resLo     = loReg;
        resWrite  = 1'b0;
        isLong    = 1'b0;
        loadCount = '0;
        case (bus.op)
            MULT: begin
                {resHi, resLo} = prodS;
                resWrite       = 1'b1;
                isLong         = 1'b1;
                loadCount      = CW'(MULT_CYCLES);
            end
            MULTU: begin
                {resHi, resLo} = prodU;
                resWrite       = 1'b1;
                isLong         = 1'b1;
                loadCount      = CW'(MULT_CYCLES);
            end
            DIV: begin
                resHi     = rS;
                resLo     = qS;
                resWrite  = (bus.B != 32'd0);
                isLong    = 1'b1;
                loadCount = CW'(DIV_CYCLES);
            end
            DIVU: begin
                resHi     = rU;
                resLo     = qU;
                resWrite  = (bus.B != 32'd0);
                isLong    = 1'b1;
                loadCount = CW'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            MADD: begin
                {resHi, resLo} = {hiReg, loReg} + prodS;
                resWrite       = 1'b1;
                isLong         = 1'b1;
                loadCount      = CW'(MULT_CYCLES);
            end
            MADDU: begin
                {resHi, resLo} = {hiReg, loReg} + prodU;
                resWrite       = 1'b1;
                isLong         = 1'b1;
                loadCount      = CW'(MULT_CYCLES);
            end
            MSUB: begin
                {resHi, resLo} = {hiReg, loReg} - prodS;
                resWrite       = 1'b1;
                isLong         = 1'b1;
                loadCount      = CW'(MULT_CYCLES);
            end
            MSUBU: begin
                {resHi, resLo} = {hiReg, loReg} - prodU;
                resWrite       = 1'b1;
                isLong         = 1'b1;
                loadCount      = CW'(MULT_CYCLES);
            end
`endif
            default: ;
        endcase
    end

    assign opValid = isLong || (bus.op == MTHI) || (bus.op == MTLO);
    assign issue   = bus.start && !bus.req && !busy && opValid;

    mdu_ctrl #(.CW(CW)) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .issue     (issue && isLong),
        .loadCount (loadCount),
        .busy      (busy),
        .commit    (commit)
    );

    // Results wait in the pending registers so HI/LO never show them early
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hiReg     <= 32'd0;
            loReg     <= 32'd0;
            pendHi    <= 32'd0;
            pendLo    <= 32'd0;
            pendWrite <= 1'b0;
        end else begin
            if (issue && bus.op == MTHI) hiReg <= bus.A;
            if (issue && bus.op == MTLO) loReg <= bus.A;
            if (issue && isLong) begin
                pendHi    <= resHi;
                pendLo    <= resLo;
                pendWrite <= resWrite;
            end
            if (commit && pendWrite) begin
                hiReg <= pendHi;
                loReg <= pendLo;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.HI   = hiReg;
    assign bus.LO   = loReg;

endmodule
